// File: rtl/rf68000_ring_node_q.sv
// rf68000 ring node with queued injection (TX FIFO) and extraction (RX FIFO),
// age-based removal of orphan packets and originator removal of broadcasts.
module rf68000_ring_node_q #(
    parameter int unsigned ID_W      = 6,
    parameter int unsigned AGE_W     = 6,
    parameter int unsigned PKT_W     = 96,
    parameter int unsigned TXQ_DEPTH = 4,
    parameter int unsigned RXQ_DEPTH = 4,
    parameter int unsigned MAX_AGE   = 62
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [ID_W-1:0]                id_i,
    input  logic [PKT_W-1:0]               ring_i,
    output logic [PKT_W-1:0]               ring_o,
    input  logic                           tx_valid_i,
    input  logic [PKT_W-1:0]               tx_pkt_i,
    output logic                           tx_ready_o,
    output logic                           rx_valid_o,
    output logic [PKT_W-1:0]               rx_pkt_o,
    input  logic                           rx_ready_i,
    output logic [$clog2(TXQ_DEPTH+1)-1:0] tx_level_o,
    output logic [$clog2(RXQ_DEPTH+1)-1:0] rx_level_o,
    output logic                           drop_o,
    output logic [15:0]                    drop_cnt_o
);

    localparam int unsigned TXLW   = $clog2(TXQ_DEPTH + 1);
    localparam int unsigned RXLW   = $clog2(RXQ_DEPTH + 1);
    localparam int unsigned TXPW   = $clog2(TXQ_DEPTH);
    localparam int unsigned RXPW   = $clog2(RXQ_DEPTH);
    localparam int unsigned SID_LO = ID_W;
    localparam int unsigned SID_HI = 2 * ID_W - 1;
    localparam int unsigned AGE_LO = 2 * ID_W;
    localparam int unsigned AGE_HI = 2 * ID_W + AGE_W - 1;

    logic [PKT_W-1:0] tx_mem_q [TXQ_DEPTH];
    logic [TXPW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TXLW-1:0]  tx_cnt_q, tx_cnt_d;

    logic [PKT_W-1:0] rx_mem_q [RXQ_DEPTH];
    logic [RXPW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RXLW-1:0]  rx_cnt_q, rx_cnt_d;

    logic [PKT_W-1:0] ring_q, ring_d;
    logic             drop_q, drop_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [ID_W-1:0]  did, sid;
    logic [AGE_W-1:0] age;
    logic [PKT_W-1:0] fwd_pkt, pass_pkt, tx_head, inj_pkt;
    logic             tx_full, tx_empty, rx_full;
    logic             tx_push, tx_pop, rx_push, rx_pop, rx_space;
    logic             slot_free, drop_now;

    assign did = ring_i[ID_W-1:0];
    assign sid = ring_i[SID_HI:SID_LO];
    assign age = ring_i[AGE_HI:AGE_LO];

    assign tx_full  = (tx_cnt_q == TXLW'(TXQ_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RXLW'(RXQ_DEPTH));

    assign tx_ready_o = rst_ni && !tx_full;
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign rx_valid_o = (rx_cnt_q != '0);
    assign rx_pkt_o   = rx_mem_q[rx_rptr_q];
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign rx_space   = !rx_full || rx_pop;
    assign tx_head    = tx_mem_q[tx_rptr_q];

    always_comb begin
        fwd_pkt = ring_i;
        fwd_pkt[AGE_HI:AGE_LO] = (age == '1) ? age : age + 1'b1;
        inj_pkt = tx_head;
        inj_pkt[SID_HI:SID_LO] = id_i;
        inj_pkt[AGE_HI:AGE_LO] = '0;
    end

    // Slot decision in priority order; removed/received slots leave as all-zero.
    always_comb begin
        slot_free = 1'b0;
        rx_push   = 1'b0;
        drop_now  = 1'b0;
        pass_pkt  = fwd_pkt;
        if (did == '0) begin
            slot_free = 1'b1;
            pass_pkt  = ring_i;
        end else if (age >= AGE_W'(MAX_AGE) && did != id_i) begin
            slot_free = 1'b1;
            drop_now  = 1'b1;
            pass_pkt  = '0;
        end else if (did == id_i) begin
            if (rx_space) begin
                rx_push   = 1'b1;
                slot_free = 1'b1;
                pass_pkt  = '0;
            end
        end else if (did == '1) begin
            if (sid == id_i) begin
                slot_free = 1'b1;
                pass_pkt  = '0;
            end else begin
                rx_push = rx_space;
            end
        end
    end

    // A did==0 TX head consumes the free slot without being injected.
    always_comb begin
        tx_pop = slot_free && !tx_empty;
        ring_d = pass_pkt;
        if (tx_pop && tx_head[ID_W-1:0] != '0) begin
            ring_d = inj_pkt;
        end
    end

    always_comb begin
        tx_wptr_d = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d = tx_pop ? tx_rptr_q + 1'b1 : tx_rptr_q;
        unique case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        rx_wptr_d = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d = rx_pop ? rx_rptr_q + 1'b1 : rx_rptr_q;
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        drop_d     = drop_now;
        drop_cnt_d = (drop_now && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            ring_q     <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            ring_q     <= ring_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= tx_pkt_i;
        end
        if (rst_ni && rx_push) begin
            rx_mem_q[rx_wptr_q] <= ring_i;
        end
    end

    assign ring_o     = ring_q;
    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;
    assign tx_level_o = tx_cnt_q;
    assign rx_level_o = rx_cnt_q;

endmodule

// File: tb/tb_rf68000_ring_node_q.sv
// Self-checking bench for rf68000_ring_node_q: queue-based reference model checked
// every cycle, plus hand-computed packet literals for the directed scenarios.
module tb_rf68000_ring_node_q;

    localparam int ID   = 3;
    localparam int TXD  = 4;
    localparam int RXD  = 4;
    localparam int MAXA = 62;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  id;
    logic [95:0] ring_in, ring_out, tx_pkt, rx_pkt;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, drop;
    logic [2:0]  tx_level, rx_level;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    rf68000_ring_node_q #(
        .ID_W(6), .AGE_W(6), .PKT_W(96), .TXQ_DEPTH(TXD), .RXQ_DEPTH(RXD), .MAX_AGE(MAXA)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .id_i(id), .ring_i(ring_in), .ring_o(ring_out),
        .tx_valid_i(tx_valid), .tx_pkt_i(tx_pkt), .tx_ready_o(tx_ready),
        .rx_valid_o(rx_valid), .rx_pkt_o(rx_pkt), .rx_ready_i(rx_ready),
        .tx_level_o(tx_level), .rx_level_o(rx_level), .drop_o(drop), .drop_cnt_o(drop_cnt)
    );

    int checks = 0;
    int failures = 0;

    logic [95:0] txq[$];
    logic [95:0] rxq[$];
    logic [95:0] exp_ring;
    logic        exp_drop;
    int          exp_cnt;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [95:0] mk(input int d, input int s, input int a, input logic [77:0] pay);
        logic [95:0] p;
        p = '0;
        p[5:0]   = d[5:0];
        p[11:6]  = s[5:0];
        p[17:12] = a[5:0];
        p[95:18] = pay;
        return p;
    endfunction

    // Reference: what happens to the arriving slot and both queues at one clock edge.
    task automatic model_edge();
        int d, s, a;
        bit free, push, pop_rx, space, txpush, drp;
        logic [95:0] out, h;
        if (!rst_n) begin
            txq.delete();
            rxq.delete();
            exp_ring = '0;
            exp_drop = 1'b0;
            exp_cnt  = 0;
            return;
        end
        d = int'(ring_in[5:0]);
        s = int'(ring_in[11:6]);
        a = int'(ring_in[17:12]);
        pop_rx = (rxq.size() > 0) && rx_ready;
        space  = (rxq.size() < RXD) || pop_rx;
        txpush = tx_valid && (txq.size() < TXD);
        free = 0; push = 0; drp = 0;
        out = ring_in;
        out[17:12] = (a == 63) ? 6'd63 : 6'(a + 1);
        if (d == 0) begin
            free = 1; out = ring_in;
        end else if (a >= MAXA && d != ID) begin
            free = 1; drp = 1; out = '0;
        end else if (d == ID) begin
            if (space) begin push = 1; free = 1; out = '0; end
        end else if (d == 63) begin
            if (s == ID) begin free = 1; out = '0; end
            else push = space;
        end
        if (free && txq.size() > 0) begin
            h = txq.pop_front();
            if (h[5:0] != 0) begin
                out = h;
                out[11:6]  = 6'(ID);
                out[17:12] = '0;
            end
        end
        if (pop_rx) void'(rxq.pop_front());
        if (push) rxq.push_back(ring_in);
        if (txpush) txq.push_back(tx_pkt);
        exp_ring = out;
        exp_drop = drp;
        if (drp && exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic compare_all();
        chk("ring_o", ring_out, exp_ring);
        chk("tx_ready", 96'(tx_ready), 96'(rst_n && txq.size() < TXD));
        chk("tx_level", 96'(tx_level), 96'(txq.size()));
        chk("rx_level", 96'(rx_level), 96'(rxq.size()));
        chk("rx_valid", 96'(rx_valid), 96'(rxq.size() > 0));
        if (rxq.size() > 0) chk("rx_pkt", rx_pkt, rxq[0]);
        chk("drop", 96'(drop), 96'(exp_drop));
        chk("drop_cnt", 96'(drop_cnt), 96'(exp_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        ring_in = '0; tx_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        id = 6'(ID);
        rst_n = 1'b0; ring_in = '0; tx_valid = 1'b0; tx_pkt = '0; rx_ready = 1'b0;
        exp_ring = '0; exp_drop = 1'b0; exp_cnt = 0;
        step(); step();
        rst_n = 1'b1;

        // Idle ring
        idle(10);
        chk("idle_ring", ring_out, 96'h0);
        chk("idle_tx_ready", 96'(tx_ready), 96'h1);
        chk("idle_levels", 96'({tx_level, rx_level}), 96'h0);
        chk("idle_drop_cnt", 96'(drop_cnt), 96'h0);

        // Single injection: did=5 payload A5
        tx_valid = 1'b1; tx_pkt = mk(5, 0, 0, 78'hA5);
        step();
        tx_valid = 1'b0;
        step();
        chk("inject_pkt", ring_out, 96'h29400C5);
        chk("inject_tx_level", 96'(tx_level), 96'h0);
        idle(2);

        // RX fill, overflow forwarding, push+pop on full
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ring_in = mk(ID, 9, 0, 78'(i + 1));
            step();
        end
        chk("rx_full_level", 96'(rx_level), 96'h4);
        ring_in = 96'h440243;
        step();
        chk("rx_overflow_fwd", ring_out, 96'h441243);
        chk("rx_overflow_level", 96'(rx_level), 96'h4);
        rx_ready = 1'b1; ring_in = mk(ID, 9, 0, 78'h66);
        step();
        chk("rx_pushpop_level", 96'(rx_level), 96'h4);
        chk("rx_pushpop_ring", ring_out, 96'h0);
        idle(6);
        chk("rx_drained", 96'(rx_level), 96'h0);
        rx_ready = 1'b0;

        // Aged-out removal with injection into the freed slot
        ring_in = mk(7, 9, 0, 78'h0); tx_valid = 1'b1; tx_pkt = mk(5, 63, 42, 78'h77);
        step();
        tx_valid = 1'b0; ring_in = mk(7, 9, 62, 78'h0);
        step();
        chk("aged_inject", ring_out, 96'h1DC00C5);
        chk("aged_drop_pulse", 96'(drop), 96'h1);
        chk("aged_drop_cnt", 96'(drop_cnt), 96'h1);
        idle(1);
        chk("aged_pulse_end", 96'(drop), 96'h0);

        // Broadcast from another node, then own broadcast returning
        ring_in = 96'h14527F;
        step();
        chk("bcast_fwd", ring_out, 96'h14627F);
        chk("bcast_rx_level", 96'(rx_level), 96'h1);
        chk("bcast_rx_pkt", rx_pkt, 96'h14527F);
        ring_in = 96'h1450FF;
        step();
        chk("bcast_own_removed", ring_out, 96'h0);
        chk("bcast_own_no_rx", 96'(rx_level), 96'h1);

        // Reset mid-stream with both FIFOs at level 2
        ring_in = 96'h14527F; tx_valid = 1'b1; tx_pkt = mk(8, 0, 0, 78'h1);
        step();
        ring_in = mk(7, 9, 0, 78'h0); tx_pkt = mk(9, 0, 0, 78'h2);
        step();
        chk("pre_reset_tx_level", 96'(tx_level), 96'h2);
        chk("pre_reset_rx_level", 96'(rx_level), 96'h2);
        rst_n = 1'b0; tx_valid = 1'b0; ring_in = mk(7, 9, 0, 78'h5);
        step();
        chk("reset_ring", ring_out, 96'h0);
        chk("reset_levels", 96'({tx_level, rx_level}), 96'h0);
        chk("reset_rx_valid", 96'(rx_valid), 96'h0);
        chk("reset_drop_cnt", 96'(drop_cnt), 96'h0);
        chk("reset_tx_ready", 96'(tx_ready), 96'h0);
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r, d, s, a;
            r = int'($urandom_range(0, 9));
            if (r < 2) d = 0;
            else if (r < 4) d = ID;
            else if (r < 6) d = 63;
            else d = int'($urandom_range(1, 62));
            s = ($urandom_range(0, 2) == 0) ? ID : int'($urandom_range(0, 63));
            a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(58, 63));
            ring_in = {$urandom, $urandom, $urandom};
            ring_in[5:0]   = 6'(d);
            ring_in[11:6]  = 6'(s);
            ring_in[17:12] = 6'(a);
            tx_valid = ($urandom_range(0, 1) == 1);
            tx_pkt   = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) tx_pkt[5:0] = '0;
            rx_ready = ($urandom_range(0, 9) < 6);
            rst_n    = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
